// File: rtl/pmod_als_sensor_emulator_if.sv
// rtl/pmod_als_sensor_emulator_if.sv - SPI pins and sample handshake of the ALS emulator
interface pmod_als_sensor_emulator_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cs;
  logic                  sck;
  logic                  sdo;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_ready;

  modport master (
    output cs, sck, sample_valid, sample_data,
    input  sdo, sample_ready
  );

  modport slave (
    input  cs, sck, sample_valid, sample_data,
    output sdo, sample_ready
  );
endinterface

// File: rtl/pmod_als_sensor_emulator.sv
// rtl/pmod_als_sensor_emulator.sv - SPI responder emulating the PMOD ALS 8-bit light sensor
module pmod_als_sensor_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pmod_als_sensor_emulator_if.slave      bus,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           short_frame,
  output logic [15:0]                    frame_count
);
  localparam int CW = $clog2(FRAME_BITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, fill_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s, sync_valid;
  logic                   cs_fall, cs_rise, sck_fall;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sdo_q, sdo_d;
  logic [DATA_WIDTH-1:0]  cur_q, cur_d, pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
  logic                   armed_q, armed_d;
  logic                   done_q, done_d, short_q, short_d;
  logic [15:0]            count_q, count_d;
  logic [FRAME_BITS-1:0]  frame, frame_sh;

  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  // Synchronizer reset values are not real pin samples; fill_q marks when they are.
  assign sync_valid = fill_q[SYNC_STAGES-1];
  assign cs_fall    = cs_prev_q & ~cs_s;
  assign cs_rise    = ~cs_prev_q & cs_s;
  assign sck_fall   = sck_prev_q & ~sck_s;

  assign frame    = FRAME_BITS'({cur_q, 5'b00000});
  assign frame_sh = frame << cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '1;
      fill_q     <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sdo_q       <= 1'b0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sdo_q       <= sdo_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      short_q     <= short_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sdo_d       = sdo_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    armed_d     = armed_q | (sync_valid & cs_s);
    done_d      = 1'b0;
    short_d     = 1'b0;
    count_d     = count_q;

    if (bus.sample_valid && !pend_full_q) begin
      pend_d      = bus.sample_data;
      pend_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        // cs_rise outranks a coincident sck fall, which is then not counted.
        if (cs_rise) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
          if (cnt_q == CW'(FRAME_BITS)) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
          end else begin
            short_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (cnt_q != CW'(FRAME_BITS)) begin
            sdo_d = frame_sh[FRAME_BITS-1];
            cnt_d = cnt_q + CW'(1);
          end else begin
            sdo_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sdo          = sdo_q;
  assign bus.sample_ready = ~pend_full_q;
  assign busy             = (state_q == SHIFT);
  assign frame_done       = done_q;
  assign short_frame      = short_q;
  assign frame_count      = count_q;
endmodule
